col_pair_scheduler: RTL
=======================

COL_PAIR_SCHEDULER -- requirements
Module: col_pair_scheduler

Interface
REQ-001 Parameter ADDR_W, default 11, width of nonzero-index and pointer values.
REQ-002 Parameter COL_W, default 8, width of column index and column count.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a pass over columns 0..num_cols-1.
REQ-006 num_cols  input  COL_W  column count; sampled on accepted start.
REQ-007 busy  output  1  high from the cycle after accepted start until done.
REQ-008 done  output  1  one-cycle pulse when the pass completes.
REQ-009 ptr_rd_en / ptr_addr  output  1 / COL_W+1  column-pointer memory read strobe and address.
REQ-010 ptr_data  input  ADDR_W  pointer read data, valid exactly 1 cycle after ptr_rd_en.
REQ-011 addr_even / addr_odd  output  ADDR_W  nonzero-array indices issued as a pair.
REQ-012 valid_even / valid_odd  output  1  qualify the respective index.
REQ-013 issue_ready  input  1  datapath accepts the current pair when high with valid_even.
REQ-014 col_idx  output  COL_W  column the current pair belongs to.
REQ-015 col_done  output  1  one-cycle pulse when a column (including empty) finishes.
REQ-016 ptr_err  output  1  sticky flag: a column had end pointer < start pointer.

Function
REQ-017 FSM states SHALL be IDLE, PTR_A, PTR_B, PTR_C, ISSUE, NEXT_COL, FIN.
REQ-018 IDLE: start accepted only in IDLE; start in any other state SHALL be ignored.
REQ-019 start with num_cols=0 SHALL go IDLE->FIN; done pulses the following cycle, no pointer reads.
REQ-020 PTR_A: ptr_rd_en=1, ptr_addr=j; PTR_B: ptr_rd_en=1, ptr_addr=j+1, capture lo=ptr_data; PTR_C: capture hi=ptr_data.
REQ-021 PTR_C -> ISSUE when hi>lo (unsigned); otherwise -> NEXT_COL, and if hi<lo set ptr_err.
REQ-022 In ISSUE, even index register starts at lo, odd at lo+1; addr_even=even, addr_odd=odd.
REQ-023 valid_even=1 throughout ISSUE; valid_odd=(odd<hi).
REQ-024 Pair accepted when valid_even&issue_ready; both indices then advance by 2 next cycle.
REQ-025 Without issue_ready, indices and valids SHALL hold stable (no drop, no duplicate).
REQ-026 Last pair: accepted pair with even+2>=hi SHALL move to NEXT_COL; odd-count column ends with valid_odd=0.
REQ-027 NEXT_COL: col_done=1 for one cycle; j increments; j==num_cols-1 -> FIN, else -> PTR_A.
REQ-028 FIN: done=1 one cycle, busy drops same cycle, -> IDLE.
REQ-029 Index arithmetic ADDR_W bits wide, pointer address COL_W+1 bits so j+1 never wraps.
REQ-030 Throughput: one pair per cycle under continuous issue_ready; 3-cycle pointer overhead plus 1 NEXT_COL cycle per column.

Reset
REQ-031 reset SHALL dominate every other input, in any state, including mid-ISSUE.
REQ-032 After reset: state IDLE, busy=done=col_done=ptr_rd_en=valid_even=valid_odd=ptr_err=0, addr_even=0, addr_odd=1, col_idx=0, ptr_addr=0.

Structure
REQ-033 Shared package SHALL hold the FSM state encoding and default ADDR_W/COL_W constants.
REQ-034 The even/odd index stepping SHALL be one sub-module, pair_index_counter (load base, step 2 on enable, outputs base and base+1).
REQ-035 Block SHALL be fully synchronous, single clock domain, no latches.

Verification
REQ-036 num_cols=1, ptr={0,5}, issue_ready=1 -> pairs (0,1),(2,3),(4,-) with valid_odd=0 on last; col_done then done.
REQ-037 num_cols=3, ptr={0,4,4,6} -> col0 pairs (0,1),(2,3); col1 empty, col_done only; col2 pair (4,5); three col_done, one done.
REQ-038 ptr={0,6}, issue_ready toggled 1,0,0,1,1 -> addresses hold during low cycles, exactly 3 pairs accepted.
REQ-039 reset asserted during ISSUE of column 2 -> next cycle all outputs at REQ-032 values; new start runs from column 0.
REQ-040 num_cols=0 start -> done one cycle later, ptr_rd_en never high; ptr={3,1} -> ptr_err=1, column skipped, sticky until reset.
REQ-041 start pulsed while busy -> ignored, pass result unchanged.

Source files
------------

// File: rtl/col_pair_scheduler_pkg.sv
// Shared definitions for the column pair scheduler: default widths and FSM encoding.
package col_pair_scheduler_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_COL_W  = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PTR_A    = 3'd1,
        PTR_B    = 3'd2,
        PTR_C    = 3'd3,
        ISSUE    = 3'd4,
        NEXT_COL = 3'd5,
        FIN      = 3'd6
    } state_t;

endpackage

// File: rtl/col_pair_scheduler_if.sv
// Pointer-memory read port and pair-issue port of the column pair scheduler.
interface col_pair_scheduler_if
    import col_pair_scheduler_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int COL_W  = DEF_COL_W
) ();

    logic              ptr_rd_en;
    logic [COL_W:0]    ptr_addr;
    logic [ADDR_W-1:0] ptr_data;

    logic [ADDR_W-1:0] addr_even;
    logic [ADDR_W-1:0] addr_odd;
    logic              valid_even;
    logic              valid_odd;
    logic              issue_ready;
    logic [COL_W-1:0]  col_idx;
    logic              col_done;

    modport master (
        output ptr_rd_en, ptr_addr, addr_even, addr_odd, valid_even, valid_odd,
               col_idx, col_done,
        input  ptr_data, issue_ready
    );

    modport slave (
        input  ptr_rd_en, ptr_addr, addr_even, addr_odd, valid_even, valid_odd,
               col_idx, col_done,
        output ptr_data, issue_ready
    );

endinterface

// File: rtl/col_pair_scheduler_pair_index_counter.sv
// Even/odd nonzero-index pair: loads a base, steps by two, presents base and base+1.
module pair_index_counter
    import col_pair_scheduler_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_in,
    input  logic              step,
    output logic [ADDR_W-1:0] even,
    output logic [ADDR_W-1:0] odd
);

    logic [ADDR_W-1:0] base;

    always_ff @(posedge clk) begin
        if (reset) begin
            base <= '0;
        end else if (load) begin
            base <= base_in;
        end else if (step) begin
            base <= base + ADDR_W'(2);
        end
    end

    assign even = base;
    assign odd  = base + ADDR_W'(1);

endmodule

// File: rtl/col_pair_scheduler.sv
// Walks columns 0..num_cols-1, reads each column's [start,end) pointers and issues
// the column's nonzero indices as even/odd pairs under issue_ready back-pressure.
module col_pair_scheduler
    import col_pair_scheduler_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int COL_W  = DEF_COL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [COL_W-1:0] num_cols,
    output logic             busy,
    output logic             done,
    output logic             ptr_err,
    col_pair_scheduler_if.master bus
);

    state_t            state;
    state_t            next_state;
    logic [COL_W-1:0]  j;
    logic [COL_W-1:0]  ncols_r;
    logic [ADDR_W-1:0] lo;
    logic [ADDR_W-1:0] hi;
    logic [ADDR_W-1:0] even;
    logic [ADDR_W-1:0] odd;
    logic              accept;
    logic              last_pair;
    logic              last_col;

    assign accept    = (state == ISSUE) && bus.issue_ready;
    // Widened by one bit so the end-of-column test cannot be fooled by wrap-around.
    assign last_pair = ({1'b0, even} + (ADDR_W+1)'(2)) >= {1'b0, hi};
    assign last_col  = (j == ncols_r - COL_W'(1));

    pair_index_counter #(.ADDR_W(ADDR_W)) u_pair_index_counter (
        .clk     (clk),
        .reset   (reset),
        .load    (state == PTR_C),
        .base_in (lo),
        .step    (accept),
        .even    (even),
        .odd     (odd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = (num_cols == '0) ? FIN : PTR_A;
            PTR_A:    next_state = PTR_B;
            PTR_B:    next_state = PTR_C;
            PTR_C:    next_state = (bus.ptr_data > lo) ? ISSUE : NEXT_COL;
            ISSUE:    if (accept && last_pair) next_state = NEXT_COL;
            NEXT_COL: next_state = last_col ? FIN : PTR_A;
            FIN:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Column bookkeeping; j returns to 0 after the last column so col_idx idles at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            j       <= '0;
            ncols_r <= '0;
            lo      <= '0;
            hi      <= '0;
            ptr_err <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                ncols_r <= num_cols;
                j       <= '0;
            end
            if (state == PTR_B) begin
                lo <= bus.ptr_data;
            end
            if (state == PTR_C) begin
                hi <= bus.ptr_data;
                if (bus.ptr_data < lo) begin
                    ptr_err <= 1'b1;
                end
            end
            if (state == NEXT_COL) begin
                j <= last_col ? '0 : j + COL_W'(1);
            end
        end
    end

    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        bus.ptr_rd_en  = 1'b0;
        bus.ptr_addr   = '0;
        bus.valid_even = 1'b0;
        bus.valid_odd  = 1'b0;
        bus.col_done   = 1'b0;
        case (state)
            PTR_A: begin
                busy          = 1'b1;
                bus.ptr_rd_en = 1'b1;
                bus.ptr_addr  = {1'b0, j};
            end
            PTR_B: begin
                busy          = 1'b1;
                bus.ptr_rd_en = 1'b1;
                bus.ptr_addr  = {1'b0, j} + (COL_W+1)'(1);
            end
            PTR_C: begin
                busy = 1'b1;
            end
            ISSUE: begin
                busy           = 1'b1;
                bus.valid_even = 1'b1;
                bus.valid_odd  = (odd < hi);
            end
            NEXT_COL: begin
                busy         = 1'b1;
                bus.col_done = 1'b1;
            end
            FIN: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign bus.addr_even = even;
    assign bus.addr_odd  = odd;
    assign bus.col_idx   = j;

endmodule
